// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if: requester, ALU and consumer handshakes plus the
// register-bank load enables driven by alu_op_sequencer.
// master = the sequencer, slave = the surrounding datapath/requester/consumer.
interface alu_op_sequencer_if #(
    parameter int unsigned CNT_W = 8
);
    logic             start_valid;
    logic             start_unary;
    logic             start_ready;
    logic             ld_a;
    logic             ld_b;
    logic             ld_op;
    logic             alu_start;
    logic             alu_done;
    logic             ld_res;
    logic             res_valid;
    logic             res_err;
    logic             res_ready;
    logic             busy;
    logic [CNT_W-1:0] done_count;

    modport master (
        input  start_valid, start_unary, alu_done, res_ready,
        output start_ready, ld_a, ld_b, ld_op, alu_start, ld_res,
               res_valid, res_err, busy, done_count
    );

    modport slave (
        output start_valid, start_unary, alu_done, res_ready,
        input  start_ready, ld_a, ld_b, ld_op, alu_start, ld_res,
               res_valid, res_err, busy, done_count
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: accepts one ALU operation per valid/ready handshake, pulses
// the operand/opcode bank enables, starts the ALU, waits for completion and
// presents the captured result until the consumer takes it.
// Optional watchdog on the ALU wait: define ALU_OP_SEQ_WATCHDOG_EN.
module alu_op_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 8
) (
    input  logic               clk,
    input  logic               resetn,
    alu_op_sequencer_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_e;

    state_e           state_q;
    state_e           state_d;
    logic             accept;
    logic             timeout;
    logic             res_hs;
    logic             start_ready;
    logic             ld_a;
    logic             ld_b;
    logic             ld_op;
    logic             alu_start;
    logic             ld_res;
    logic             res_valid;
    logic [CNT_W-1:0] done_count_q;
    logic [CNT_W-1:0] done_count_d;

    if (TIMEOUT_CYCLES < 2) begin : g_timeout_check
        $error("alu_op_sequencer: TIMEOUT_CYCLES must be at least 2");
    end

    // Gating with resetn keeps start_ready (and so every load enable) low for
    // the whole reset, and high again in the first cycle after release.
    assign accept = (state_q == S_IDLE) && resetn && bus.start_valid;

    // Next-state and load-enable decode; all outputs default low.
    always_comb begin
        state_d      = state_q;
        start_ready  = 1'b0;
        ld_a         = 1'b0;
        ld_b         = 1'b0;
        ld_op        = 1'b0;
        alu_start    = 1'b0;
        ld_res       = 1'b0;
        res_valid    = 1'b0;
        res_hs       = 1'b0;
        done_count_d = done_count_q;
        unique case (state_q)
            S_IDLE: begin
                start_ready = resetn;
                if (accept) begin
                    ld_a    = 1'b1;
                    ld_op   = 1'b1;
                    ld_b    = ~bus.start_unary;
                    state_d = S_EXEC;
                end
            end
            S_EXEC, S_WAIT: begin
                alu_start = (state_q == S_EXEC);
                if (bus.alu_done) begin
                    ld_res  = 1'b1;
                    state_d = S_HOLD;
                end else if (timeout) begin
                    state_d = S_HOLD;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_HOLD: begin
                res_valid = 1'b1;
                if (bus.res_ready) begin
                    res_hs       = 1'b1;
                    done_count_d = done_count_q + 1'b1;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register and completed-operation counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            done_count_q <= '0;
        end else begin
            state_q      <= state_d;
            done_count_q <= done_count_d;
        end
    end

`ifdef ALU_OP_SEQ_WATCHDOG_EN
    localparam int unsigned    WD_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);

    logic            in_alu;
    logic [WD_W-1:0] wd_q;
    logic [WD_W-1:0] wd_d;
    logic            res_err_q;
    logic            res_err_d;

    assign in_alu = (state_q == S_EXEC) || (state_q == S_WAIT);

    // Watchdog: the counter is 0 in the alu_start cycle, so testing the
    // incremented value makes the abort land TIMEOUT_CYCLES after alu_start;
    // alu_done in that same cycle takes priority in the state decode.
    always_comb begin
        wd_d      = wd_q;
        res_err_d = res_err_q;
        timeout   = 1'b0;
        if (accept) begin
            wd_d      = '0;
            res_err_d = 1'b0;
        end else if (in_alu && !bus.alu_done) begin
            wd_d = wd_q + 1'b1;
            if (wd_d == WD_LIMIT) begin
                timeout   = 1'b1;
                res_err_d = 1'b1;
            end
        end
    end

    // Watchdog counter and abort flag registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wd_q      <= '0;
            res_err_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            res_err_q <= res_err_d;
        end
    end

    assign bus.res_err = res_err_q;
`else
    assign timeout     = 1'b0;
    assign bus.res_err = 1'b0;
`endif

    assign bus.start_ready = start_ready;
    assign bus.ld_a        = ld_a;
    assign bus.ld_b        = ld_b;
    assign bus.ld_op       = ld_op;
    assign bus.alu_start   = alu_start;
    assign bus.ld_res      = ld_res;
    assign bus.res_valid   = res_valid;
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done_count  = done_count_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: drives operations through alu_op_sequencer, checks the
// per-cycle enables inline and scoreboards result handshakes (res_err and the
// completed-operation count) in a separate monitor.
`timescale 1ns/1ps
module tb_alu_op_sequencer;
    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned CW      = 8;

    logic clk    = 1'b0;
    logic resetn = 1'b0;

    alu_op_sequencer_if #(.CNT_W(CW)) bus ();

    alu_op_sequencer #(.TIMEOUT_CYCLES(TIMEOUT), .CNT_W(CW)) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    bit          exp_q[$];
    logic [CW-1:0] hs_cnt = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Scoreboard side: every result handshake pops the expected error flag
    // and checks the count of handshakes completed before this one.
    initial begin
        bit exp_e;
        forever begin
            @(negedge clk);
            #2;
            if (resetn && bus.res_valid && bus.res_ready) begin
                check_eq("sb_item", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    exp_e = exp_q.pop_front();
                    check_eq("sb_res_err", bus.res_err, exp_e);
                end
                check_eq("sb_done_count", bus.done_count, hs_cnt);
                hs_cnt = hs_cnt + 1'b1;
            end
        end
    end

    // dly: cycles after alu_start until alu_done (0 = same cycle, <0 = never).
    // hold: cycles res_ready stays low in HOLD while a new request is offered.
    task automatic run_op(input bit unary, input int dly, input int hold);
        int n;
        bit exp_err;
        exp_err = (dly < 0);
        @(negedge clk);
        bus.res_ready   = 1'b0;
        bus.start_valid = 1'b1;
        bus.start_unary = unary;
        bus.alu_done    = 1'b0;
        #1;
        check_eq("acc_ready", bus.start_ready, 1);
        check_eq("acc_busy", bus.busy, 0);
        check_eq("acc_ld_a", bus.ld_a, 1);
        check_eq("acc_ld_op", bus.ld_op, 1);
        check_eq("acc_ld_b", bus.ld_b, !unary);
        check_eq("acc_alu_start", bus.alu_start, 0);
        exp_q.push_back(exp_err);

        @(negedge clk);
        bus.start_valid = 1'b0;
        bus.alu_done    = (dly == 0);
        #1;
        check_eq("exec_alu_start", bus.alu_start, 1);
        check_eq("exec_busy", bus.busy, 1);
        check_eq("exec_ld_a", bus.ld_a, 0);
        check_eq("exec_ld_b", bus.ld_b, 0);
        check_eq("exec_ld_op", bus.ld_op, 0);
        check_eq("exec_ld_res", bus.ld_res, dly == 0);
        check_eq("exec_res_valid", bus.res_valid, 0);

        if (dly > 0) begin
            for (int k = 1; k <= dly; k++) begin
                @(negedge clk);
                bus.alu_done = (k == dly);
                #1;
                check_eq("wait_alu_start", bus.alu_start, 0);
                check_eq("wait_ld_b", bus.ld_b, 0);
                check_eq("wait_ld_res", bus.ld_res, k == dly);
                check_eq("wait_res_valid", bus.res_valid, 0);
            end
        end else if (dly < 0) begin
            n = 0;
            while (n < 40 && bus.res_valid !== 1'b1) begin
                @(negedge clk);
                #1;
                n++;
                check_eq("wd_ld_res", bus.ld_res, 0);
            end
            check_eq("wd_latency", n, TIMEOUT);
        end

        if (dly >= 0) begin
            @(negedge clk);
            bus.alu_done = 1'b0;
            #1;
        end
        check_eq("hold_res_valid", bus.res_valid, 1);
        check_eq("hold_res_err", bus.res_err, exp_err);
        check_eq("hold_ld_res", bus.ld_res, 0);
        check_eq("hold_ready", bus.start_ready, 0);
        check_eq("hold_busy", bus.busy, 1);
        check_eq("hold_alu_start", bus.alu_start, 0);

        if (hold == 0) begin
            bus.res_ready = 1'b1;
        end else begin
            bus.start_valid = 1'b1;
            bus.start_unary = 1'b0;
            for (int k = 1; k < hold; k++) begin
                @(negedge clk);
                #1;
                check_eq("stall_res_valid", bus.res_valid, 1);
                check_eq("stall_ready", bus.start_ready, 0);
                check_eq("stall_ld_a", bus.ld_a, 0);
            end
            @(negedge clk);
            #1;
            check_eq("hs_res_valid", bus.res_valid, 1);
            check_eq("hs_ld_a", bus.ld_a, 0);
            bus.res_ready = 1'b1;
        end
    endtask

    task automatic end_ops();
        @(negedge clk);
        bus.res_ready   = 1'b0;
        bus.start_valid = 1'b0;
        #1;
        check_eq("idle_ready", bus.start_ready, 1);
        check_eq("idle_busy", bus.busy, 0);
        check_eq("idle_res_valid", bus.res_valid, 0);
    endtask

    // Accept an operation, stall the ALU wait_n cycles, then pull resetn low.
    task automatic abort_in_wait(input int wait_n);
        @(negedge clk);
        bus.res_ready   = 1'b0;
        bus.start_valid = 1'b1;
        bus.start_unary = 1'b0;
        bus.alu_done    = 1'b0;
        @(negedge clk);
        bus.start_valid = 1'b0;
        for (int k = 0; k < wait_n; k++) begin
            @(negedge clk);
            #1;
            check_eq("stuck_busy", bus.busy, 1);
            check_eq("stuck_res_valid", bus.res_valid, 0);
            check_eq("stuck_alu_start", bus.alu_start, 0);
        end
        #2;
        resetn = 1'b0;
        #1;
        check_eq("abort_busy", bus.busy, 0);
        check_eq("abort_res_valid", bus.res_valid, 0);
        check_eq("abort_ready", bus.start_ready, 0);
        check_eq("abort_done_count", bus.done_count, 0);
        check_eq("abort_res_err", bus.res_err, 0);
        exp_q.delete();
        hs_cnt = '0;
        @(negedge clk);
        #1;
        check_eq("abort_hold_busy", bus.busy, 0);
        resetn = 1'b1;
        #1;
        check_eq("abort_release_ready", bus.start_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got running exp finished");
        $fatal(1);
    end

    initial begin
        bus.start_valid = 1'b1;
        bus.start_unary = 1'b0;
        bus.alu_done    = 1'b0;
        bus.res_ready   = 1'b0;
        resetn          = 1'b0;

        repeat (3) begin
            @(negedge clk);
            #1;
            check_eq("rst_ld_a", bus.ld_a, 0);
            check_eq("rst_ld_b", bus.ld_b, 0);
            check_eq("rst_ld_op", bus.ld_op, 0);
            check_eq("rst_ready", bus.start_ready, 0);
            check_eq("rst_alu_start", bus.alu_start, 0);
            check_eq("rst_ld_res", bus.ld_res, 0);
            check_eq("rst_busy", bus.busy, 0);
            check_eq("rst_res_valid", bus.res_valid, 0);
            check_eq("rst_res_err", bus.res_err, 0);
            check_eq("rst_done_count", bus.done_count, 0);
        end

        @(negedge clk);
        resetn = 1'b1;
        #1;
        check_eq("rel_ready", bus.start_ready, 1);
        check_eq("rel_ld_a", bus.ld_a, 1);
        check_eq("rel_ld_b", bus.ld_b, 1);
        check_eq("rel_ld_op", bus.ld_op, 1);
        exp_q.push_back(1'b0);
        @(negedge clk);
        bus.start_valid = 1'b0;
        bus.alu_done    = 1'b1;
        #1;
        check_eq("rel_alu_start", bus.alu_start, 1);
        check_eq("rel_ld_res", bus.ld_res, 1);
        @(negedge clk);
        bus.alu_done  = 1'b0;
        bus.res_ready = 1'b1;
        #1;
        check_eq("rel_res_valid", bus.res_valid, 1);

        run_op(1'b0, 3, 0);
        run_op(1'b1, 0, 0);
        run_op(1'b0, 2, 5);
        run_op(1'b0, 0, 0);
        run_op(1'b1, TIMEOUT - 1, 0);
`ifdef ALU_OP_SEQ_WATCHDOG_EN
        run_op(1'b0, -1, 0);
        run_op(1'b0, 1, 0);
        abort_in_wait(3);
`else
        abort_in_wait(40);
`endif

        for (int i = 0; i < 256; i++) begin
            run_op(1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), 0);
        end
        end_ops();
        check_eq("wrap_done_count", bus.done_count, 0);
        check_eq("wrap_sb_empty", exp_q.size(), 0);

        #5;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Control-only sequencer that drives the load enables of the ALU's operand, opcode and result register banks, which are built from enabled D flip-flops. It accepts one operation per valid/ready handshake, loads the operands, starts the ALU, waits for completion, and captures and presents the result. An optional watchdog covers multi-cycle ALU operations.

## Interface
- TIMEOUT_CYCLES, 16, maximum cycles from alu_start to alu_done before abort (≥2; used only with watchdog)
- CNT_W, 8, width of completed-operation counter
- clk  in  1  clock; all state changes on rising edge
- resetn  in  1  reset, asynchronous, active-low
- start_valid  in  1  requester has an operation (operands/opcode stable on datapath buses)
- start_unary  in  1  qualifies start_valid; 1 = single-operand op, B register not loaded
- start_ready  out  1  sequencer can accept an operation
- ld_a  out  1  enable to operand-A register bank
- ld_b  out  1  enable to operand-B register bank
- ld_op  out  1  enable to opcode register bank
- alu_start  out  1  one-cycle start pulse to ALU
- alu_done  in  1  ALU result valid on ALU output bus
- ld_res  out  1  enable to result register bank
- res_valid  out  1  result register holds a result for consumer
- res_err  out  1  qualifies res_valid; 1 = aborted by watchdog, result register not updated
- res_ready  in  1  consumer accepts result
- busy  out  1  state ≠ IDLE
- done_count  out  CNT_W  number of result handshakes completed, wraps modulo 2^CNT_W

## Operation
- States: IDLE, EXEC, WAIT, HOLD (registered, one-hot or binary at implementer's choice).
- IDLE: start_ready=1. Accept = start_valid & start_ready. On accept: ld_a=1, ld_op=1, ld_b=~start_unary (combinational, same cycle, so the banks capture at the accepting edge); res_err cleared; next EXEC.
- EXEC: alu_start=1 for exactly this cycle. If alu_done=1: ld_res=1, next HOLD. Else next WAIT.
- WAIT: alu_start=0. If alu_done=1: ld_res=1, next HOLD. alu_done outside EXEC/WAIT is ignored.
- HOLD: res_valid=1. If res_ready=1: done_count increments (including error results), next IDLE. Otherwise remain in HOLD with res_valid held.
- ld_* and alu_start are never asserted outside the states listed above, and all are 0 while resetn=0.
- Any other combination: hold state.

## Timing
- Reset: state=IDLE; ld_a, ld_b, ld_op, ld_res, alu_start, res_valid, res_err, busy = 0; done_count=0; start_ready=0 while resetn low, 1 from the first cycle after release.
- Reset mid-operation: immediate return to IDLE with the values above; partial operation discarded; register banks keep their contents.
- Accept at edge T → alu_start high during cycle T+1.
- Single-cycle ALU (alu_done high in EXEC) → ld_res during T+1, res_valid from T+2. The minimum latency from accept to res_valid is 2 cycles.
- ALU done in cycle T+1+k → res_valid from T+2+k.
- Back-to-back throughput: result handshake at edge H → IDLE in H+1, so the next accept is no earlier than edge H+1. The minimum period is 3 cycles per operation.
- done_count wraps from 2^CNT_W−1 to 0.

## Configuration
- ALU_OP_SEQ_WATCHDOG_EN defined:
  - Counter of width $clog2(TIMEOUT_CYCLES+1), cleared on accept, increments each cycle in EXEC/WAIT without alu_done.
  - When the counter reaches TIMEOUT_CYCLES with alu_done low: ld_res stays 0, res_err set to 1, next HOLD.
  - alu_done in the same cycle as the timeout wins, giving a normal completion.
- Not defined: no counter; WAIT persists indefinitely; res_err tied 0.

## Test plan
- Reset with start_valid=1 held → all enables 0 and start_ready=0 while resetn=0; after release, ld_a=ld_b=ld_op=1 in the first cycle, then alu_start in the next.
- Binary op, alu_done asserted 3 cycles after alu_start → single ld_res pulse, res_valid after 1 more cycle, res_err=0, done_count 0→1 on res_ready.
- Unary op (start_unary=1) with single-cycle ALU → ld_b never asserted, res_valid 2 cycles after accept.
- res_ready held 0 for 5 cycles → res_valid held, start_ready=0, and new start_valid not accepted; accepted on the cycle after the handshake.
- Watchdog enabled, TIMEOUT_CYCLES=16, alu_done never asserted → res_valid with res_err=1 16 cycles after alu_start, no ld_res. Without the macro → busy stays 1.
- 256 back-to-back ops with CNT_W=8 → done_count returns to 0; assert resetn low in WAIT → IDLE immediately, res_valid=0.
